// File: rtl/riscv_pkg.sv
// Shared core definitions: data widths, fixed instruction encodings and the
// fetch_port FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = XLEN - 2;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSN     = 32'h0000_0013;
  // All-zero word is a guaranteed illegal instruction, so decode traps on it.
  localparam logic [XLEN-1:0] ILLEGAL_INSN = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_port_state_t;

endpackage : riscv_pkg

// File: rtl/fetch_port.sv
// fetch_port: instruction-side bus responder with a one-word line buffer.
// The fetch stage gets the buffered word combinationally on a hit. On a miss
// the port runs one valid/ready read on the external bus and keeps
// fetch_stall high until the word is in the buffer.
//
// Optional feature: define FETCH_PORT_TIMEOUT_EN to enable a watchdog that
// aborts a read after TIMEOUT_CYCLES WAIT cycles without ext_ready and fills
// the buffer with ERROR_WORD flagged by fetch_error.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high
//   fetch_address  PC from fetch, bits [1:0] ignored
//   fetch_data     buffered word, meaningful when fetch_stall = 0
//   fetch_stall    combinational miss indication
//   fetch_error    buffered word came from an aborted read
//   flush          invalidate the buffer (fence.i, trap entry)
//   ext_valid      registered read request
//   ext_address    registered word-aligned request address
//   ext_ready      response strobe, ext_rdata valid in the same cycle
//   ext_rdata      read data
module fetch_port
  import riscv_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES = 255,
  parameter logic [XLEN-1:0] ERROR_WORD     = ILLEGAL_INSN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_address,
  output logic [XLEN-1:0] fetch_data,
  output logic            fetch_stall,
  output logic            fetch_error,
  input  logic            flush,
  output logic            ext_valid,
  output logic [XLEN-1:0] ext_address,
  input  logic            ext_ready,
  input  logic [XLEN-1:0] ext_rdata
);

  // Line buffer and request bookkeeping
  logic             buf_valid;
  logic [TAG_W-1:0] buf_tag;
  logic [XLEN-1:0]  buf_data;
  logic [TAG_W-1:0] req_tag;
  logic             discard;

  fetch_port_state_t state;
  fetch_port_state_t state_d;

  // FSM strobes
  logic hit;
  logic issue;
  logic retire;
  logic fill_ok;
  logic set_discard;

  // Byte offset within the word has no meaning for a word buffer.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^fetch_address[1:0];

`ifdef FETCH_PORT_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic             buf_err;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             fill_err;

  // Abort on the WAIT cycle whose increment would reach the limit, so
  // ext_valid is high for exactly TIMEOUT_CYCLES cycles.
  assign timeout     = ((wait_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
  assign fetch_error = buf_err;
`else
  // Configuration knobs only matter with the watchdog built in.
  logic unused_cfg;
  assign unused_cfg  = ^{ERROR_WORD, TIMEOUT_CYCLES};
  assign fetch_error = 1'b0;
`endif

  // Hit detection and fetch-side outputs
  assign hit         = buf_valid && (buf_tag == fetch_address[XLEN-1:2]);
  assign fetch_stall = !hit;
  assign fetch_data  = buf_data;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and control strobes
  always_comb begin
    state_d     = state;
    issue       = 1'b0;
    retire      = 1'b0;
    fill_ok     = 1'b0;
    set_discard = 1'b0;
`ifdef FETCH_PORT_TIMEOUT_EN
    fill_err    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // Flush suppresses the request; the miss is retried next cycle.
        if (!hit && !flush) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ext_ready) begin
          retire  = 1'b1;
          // A same-cycle or earlier flush turns the response into a drop.
          fill_ok = !flush && !discard;
          state_d = IDLE;
        end
`ifdef FETCH_PORT_TIMEOUT_EN
        else if (timeout) begin
          retire   = 1'b1;
          fill_err = !flush && !discard;
          state_d  = IDLE;
        end
`endif
        else if (flush) begin
          set_discard = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus request, buffer and watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_valid   <= 1'b0;
      ext_address <= '0;
      req_tag     <= '0;
      discard     <= 1'b0;
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_data    <= '0;
`ifdef FETCH_PORT_TIMEOUT_EN
      buf_err     <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      // Request stays stable from issue until retire.
      if (issue) begin
        ext_valid   <= 1'b1;
        ext_address <= {fetch_address[XLEN-1:2], 2'b00};
        req_tag     <= fetch_address[XLEN-1:2];
        discard     <= 1'b0;
      end else if (retire) begin
        ext_valid   <= 1'b0;
      end

      if (set_discard) begin
        discard <= 1'b1;
      end

      // Fills never coincide with flush, so the ordering here is safe.
      if (fill_ok) begin
        buf_valid <= 1'b1;
        buf_tag   <= req_tag;
        buf_data  <= ext_rdata;
`ifdef FETCH_PORT_TIMEOUT_EN
        buf_err   <= 1'b0;
`endif
      end
`ifdef FETCH_PORT_TIMEOUT_EN
      else if (fill_err) begin
        buf_valid <= 1'b1;
        buf_tag   <= req_tag;
        buf_data  <= ERROR_WORD;
        buf_err   <= 1'b1;
      end
`endif
      else if (flush) begin
        buf_valid <= 1'b0;
      end

`ifdef FETCH_PORT_TIMEOUT_EN
      if (issue) begin
        wait_cnt <= '0;
      end else if ((state == WAIT) && !ext_ready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
`endif
    end
  end

endmodule : fetch_port
